// File: rtl/pipeline_perf_monitor_pkg.sv
// Shared types for the pipeline performance monitor: FSM state encoding,
// counter read-address map and the {pc, instr} trace entry layout.
package perf_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [2:0] ADDR_CYCLE  = 3'd0;
    localparam logic [2:0] ADDR_STALL  = 3'd1;
    localparam logic [2:0] ADDR_FLUSH  = 3'd2;
    localparam logic [2:0] ADDR_RETIRE = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    localparam int TRACE_W = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } trace_t;

endpackage

// File: rtl/pipeline_perf_monitor_if.sv
// CPU-tap / readback bundle for the performance monitor.
// master: CPU side drives taps and controls; slave: monitor drives readback and trace.
interface pipeline_perf_monitor_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             stall_i;
    logic             flush_i;
    logic             retire_i;
    logic [31:0]      pc_i;
    logic [31:0]      instr_i;
    logic [CNT_W-1:0] cycle_limit_i;
    logic             clear_i;
    logic [2:0]       rd_addr_i;
    logic [CNT_W-1:0] rd_data_o;
    logic             trace_pop_i;
    logic             trace_valid_o;
    logic [31:0]      trace_pc_o;
    logic [31:0]      trace_instr_o;
    logic             trace_ovf_o;
    logic             halt_o;

    modport master (
        output start_i, stall_i, flush_i, retire_i, pc_i, instr_i,
        output cycle_limit_i, clear_i, rd_addr_i, trace_pop_i,
        input  rd_data_o, trace_valid_o, trace_pc_o, trace_instr_o,
        input  trace_ovf_o, halt_o
    );

    modport slave (
        input  start_i, stall_i, flush_i, retire_i, pc_i, instr_i,
        input  cycle_limit_i, clear_i, rd_addr_i, trace_pop_i,
        output rd_data_o, trace_valid_o, trace_pc_o, trace_instr_o,
        output trace_ovf_o, halt_o
    );

endinterface

// File: rtl/pipeline_perf_monitor_fifo.sv
// perf_trace_fifo: retire-trace FIFO with drop-newest (MODE 0) or
// overwrite-oldest (MODE 1) on overflow. Ports: push/pop/clear in, head/empty/count/ovf out.
module perf_trace_fifo
    import perf_mon_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter bit MODE  = 1'b0,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  trace_t        data_i,
    output trace_t        head_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic          ovf_o
);

    trace_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          do_pop;
    logic          overrun;
    logic          do_write;
    logic          adv_rd;

    assign empty_o = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign count_o = count;
    assign head_o  = mem[rd_ptr];

    // A simultaneous pop frees a slot, so a full FIFO then accepts the push.
    assign do_pop   = pop_i & ~empty_o;
    assign overrun  = push_i & full & ~do_pop;
    assign do_write = push_i & (~full | do_pop | MODE);
    // Overwrite mode retires the oldest entry to make room.
    assign adv_rd   = do_pop | (overrun & MODE);

    always_ff @(posedge clk_i) begin
        if (do_write && !clear_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + AW'(1);
            if (adv_rd)   rd_ptr <= rd_ptr + AW'(1);
            if (overrun)  ovf_o  <= 1'b1;
            if (do_write && !adv_rd) begin
                count <= count + CW'(1);
            end else if (!do_write && adv_rd) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor: saturating cycle/stall/flush/retire counters, retire trace
// and cycle-limit halt. Ports: clk_i, rst_n_i, bus (slave: CPU taps in, readback/trace out).
module pipeline_perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 8,
    parameter int TRACE_MODE  = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    pipeline_perf_monitor_if.slave bus
);

    localparam int CW = $clog2(TRACE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic             halt;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] rd_next;
    logic [CNT_W-1:0] rd_data;
    logic             run;
    logic             limit_hit;
    logic             fifo_empty;
    logic             fifo_ovf;
    logic [CW-1:0]    fifo_count;
    trace_t           head;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        return (en && (v != '1)) ? v + ONE : v;
    endfunction

    assign run = (state == ST_RUN);
    // Compare against the pre-increment count so HALT lands on the limit-th edge.
    assign limit_hit = (bus.cycle_limit_i != '0) &&
                       (cycle_cnt == bus.cycle_limit_i - ONE);

    perf_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .MODE  (TRACE_MODE != 0)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (bus.clear_i),
        .push_i  (run & bus.retire_i),
        .pop_i   (bus.trace_pop_i),
        .data_i  ({bus.pc_i, bus.instr_i}),
        .head_o  (head),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .ovf_o   (fifo_ovf)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            halt       <= 1'b0;
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else if (bus.clear_i) begin
            state      <= ST_IDLE;
            halt       <= 1'b0;
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start_i) state <= ST_RUN;
                end
                ST_RUN: begin
                    cycle_cnt  <= sat_inc(cycle_cnt, 1'b1);
                    flush_cnt  <= sat_inc(flush_cnt, bus.flush_i);
                    stall_cnt  <= sat_inc(stall_cnt, bus.stall_i & ~bus.flush_i);
                    retire_cnt <= sat_inc(retire_cnt, bus.retire_i);
                    if (limit_hit) begin
                        state <= ST_HALT;
                        halt  <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                    halt  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_next = '0;
        unique case (bus.rd_addr_i)
            ADDR_CYCLE:  rd_next = cycle_cnt;
            ADDR_STALL:  rd_next = stall_cnt;
            ADDR_FLUSH:  rd_next = flush_cnt;
            ADDR_RETIRE: rd_next = retire_cnt;
            ADDR_STATUS: rd_next = CNT_W'({fifo_count, fifo_ovf, state});
            default:     rd_next = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data <= '0;
        end else if (bus.clear_i) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

    assign bus.rd_data_o     = rd_data;
    assign bus.halt_o        = halt;
    assign bus.trace_valid_o = ~fifo_empty;
    assign bus.trace_ovf_o   = fifo_ovf;
    assign bus.trace_pc_o    = head.pc;
    assign bus.trace_instr_o = head.instr;

endmodule
